// File: rtl/lmsm_pkg.sv
// rtl/lmsm_pkg.sv - shared sizes and state encoding for the LM/SM sequencer
package lmsm_pkg;

  localparam int LMSM_DATA_W = 16;
  localparam int LMSM_ADDR_W = 16;
  localparam int LMSM_NREG   = 8;
  localparam int LMSM_SEL_W  = 3;
  localparam int LMSM_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WB     = 3'd2,
    ST_DONE   = 3'd3,
    ST_UPD    = 3'd4
  } lmsm_state_t;

endpackage

// File: rtl/lmsm_prio_enc8.sv
// rtl/lmsm_prio_enc8.sv - lowest-set-bit encoder over an 8-bit register mask
module lmsm_prio_enc8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx   = 3'd0;
    valid = |mask;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM multicycle sequencer; optional base write-back under LMSM_BASE_UPDATE_EN
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int DATA_W = LMSM_DATA_W,
  parameter int ADDR_W = LMSM_ADDR_W,
  parameter int NREG   = LMSM_NREG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic [NREG-1:0]       reg_mask,
  input  logic [ADDR_W-1:0]     base_addr,
`ifdef LMSM_BASE_UPDATE_EN
  input  logic [LMSM_SEL_W-1:0] base_reg,
`endif
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LMSM_SEL_W-1:0] rf_sel,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  rf_write_n,
  output logic                  busy,
  output logic                  done,
  output logic [LMSM_CNT_W-1:0] xfer_count
);

  lmsm_state_t           state_q, state_d;
  logic [NREG-1:0]       mask_q, mask_clr;
  logic [ADDR_W-1:0]     addr_q;
  logic [LMSM_CNT_W-1:0] count_q;
  logic [DATA_W-1:0]     rf_wdata_q;
  logic                  is_load_q;
  logic [LMSM_SEL_W-1:0] cur_idx;
  logic                  cur_valid;
  logic                  more;
  logic                  advance;
  lmsm_state_t           fin_state;
`ifdef LMSM_BASE_UPDATE_EN
  logic [LMSM_SEL_W-1:0] base_reg_q;
`endif

  lmsm_prio_enc8 u_enc (
    .mask  (mask_q),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  // Pending-mask bookkeeping: drop the register being finished this cycle.
  always_comb begin
    mask_clr  = mask_q & ~(NREG'(1) << cur_idx);
    more      = |mask_clr;
    advance   = ((state_q == ST_ACCESS) && mem_ready && !is_load_q) || (state_q == ST_WB);
`ifdef LMSM_BASE_UPDATE_EN
    fin_state = ST_UPD;
`else
    fin_state = ST_DONE;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (reg_mask != '0) ? ST_ACCESS : fin_state;
      ST_ACCESS: if (mem_ready) state_d = is_load_q ? ST_WB : (more ? ST_ACCESS : fin_state);
      ST_WB:     state_d = more ? ST_ACCESS : fin_state;
      ST_DONE:   state_d = ST_IDLE;
`ifdef LMSM_BASE_UPDATE_EN
      ST_UPD:    state_d = ST_DONE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transfer datapath: latch request, then step mask/address/count per register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      rf_wdata_q <= '0;
      is_load_q  <= 1'b0;
`ifdef LMSM_BASE_UPDATE_EN
      base_reg_q <= '0;
`endif
    end else begin
      if (state_q == ST_IDLE && start) begin
        mask_q    <= reg_mask;
        addr_q    <= base_addr;
        count_q   <= '0;
        is_load_q <= is_load;
`ifdef LMSM_BASE_UPDATE_EN
        base_reg_q <= base_reg;
`endif
      end
      if (advance) begin
        mask_q  <= mask_clr;
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (state_q == ST_ACCESS && mem_ready && is_load_q) rf_wdata_q <= mem_rdata;
    end
  end

  // Output decode from registered state; mem_wdata is the only pass-through.
  always_comb begin
    mem_addr   = addr_q;
    mem_wdata  = rf_rdata;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    rf_sel     = '0;
    rf_wdata   = rf_wdata_q;
    rf_write_n = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    xfer_count = count_q;
    case (state_q)
      ST_ACCESS: begin
        busy      = 1'b1;
        rf_sel    = cur_valid ? cur_idx : '0;
        mem_read  = is_load_q;
        mem_write = !is_load_q;
      end
      ST_WB: begin
        busy       = 1'b1;
        rf_sel     = cur_valid ? cur_idx : '0;
        rf_write_n = 1'b0;
      end
`ifdef LMSM_BASE_UPDATE_EN
      ST_UPD: begin
        busy       = 1'b1;
        rf_sel     = base_reg_q;
        rf_wdata   = DATA_W'(addr_q);
        rf_write_n = 1'b0;
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
